// File: rtl/xor_shadow_mon_pkg.sv
// Shared types and limits for the XOR shadow checker.
package xor_shadow_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_e;

  localparam int unsigned LAT_MAX = 15;

endpackage

// File: rtl/xor_shadow_dly.sv
// Valid/data delay line of Depth stages; Depth 0 is a plain wire-through.
module xor_shadow_dly #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [Width-1:0] in_data,
  output logic             out_vld,
  output logic [Width-1:0] out_data
);

  if (Depth == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, flush};
    assign out_vld   = in_vld;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [Depth-1:0] vld_q;
    logic [Width-1:0] data_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
      end else if (flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_vld;
        for (int unsigned i = 1; i < Depth; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Data only matters alongside its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int unsigned i = 1; i < Depth; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign out_vld  = vld_q[Depth-1];
    assign out_data = data_q[Depth-1];
  end

endmodule

// File: rtl/xor_shadow_mon.sv
// Shadow checker: compares observed c against a^b delayed by LAT cycles, per channel.
// Define XOR_SHADOW_MON_ASSERT_EN to report each mismatching channel in simulation.
module xor_shadow_mon
  import xor_shadow_mon_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter int unsigned NCH  = 1,
  parameter int unsigned LAT  = 0,
  parameter int unsigned CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic [NCH*W-1:0]      a,
  input  logic [NCH*W-1:0]      b,
  input  logic [NCH*W-1:0]      c,
  input  logic                  clr,
  output logic                  err,
  output logic [NCH-1:0]        ch_err,
  output logic [CNTW-1:0]       mis_cnt,
  output logic [$clog2(NCH):0]  first_ch,
  output logic [1:0]            state
);

  localparam int unsigned FCW = $clog2(NCH) + 1;

  if (LAT > LAT_MAX) begin : g_bad_lat
    $error("xor_shadow_mon: LAT out of range");
  end

  logic             d_vld;
  logic [NCH*W-1:0] d_exp;
  logic [NCH-1:0]   mm;
  logic [FCW-1:0]   low_ch;

  state_e           state_q, state_d;
  logic [NCH-1:0]   ch_err_q, ch_err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [FCW-1:0]   fc_q, fc_d;

  xor_shadow_dly #(
    .Width (NCH*W),
    .Depth (LAT)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .flush    (clr),
    .in_vld   (vld),
    .in_data  (a ^ b),
    .out_vld  (d_vld),
    .out_data (d_exp)
  );

  always_comb begin
    mm = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      mm[i] = d_vld && (d_exp[i*W +: W] != c[i*W +: W]);
    end
  end

  always_comb begin
    low_ch = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mm[i]) low_ch = FCW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_err_d = ch_err_q;
    cnt_d    = cnt_q;
    fc_d     = fc_q;
    if (clr) begin
      // clr wins over any compare landing in the same cycle.
      state_d  = IDLE;
      ch_err_d = '0;
      cnt_d    = '0;
      fc_d     = '0;
    end else if (d_vld) begin
      if (|mm) begin
        if (state_q != FAIL) fc_d = low_ch;
        state_d  = FAIL;
        ch_err_d = ch_err_q | mm;
        if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else if (state_q == IDLE) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_err_q <= '0;
      cnt_q    <= '0;
      fc_q     <= '0;
    end else begin
      state_q  <= state_d;
      ch_err_q <= ch_err_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
    end
  end

  assign err      = (state_q == FAIL);
  assign ch_err   = ch_err_q;
  assign mis_cnt  = cnt_q;
  assign first_ch = fc_q;
  assign state    = state_q;

`ifdef XOR_SHADOW_MON_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (mm[i]) begin
          $error("xor_shadow_mon: ch %0d expected %0h observed %0h",
                 i, d_exp[i*W +: W], c[i*W +: W]);
        end
      end
    end
  end
`endif

endmodule
